// File: rtl/fighter_pkg.sv
// Shared fighter types and constants, used by the action sequencer,
// the gravity block and the sprite/hitbox logic.
package fighter_pkg;

    typedef enum logic [2:0] {
        POSE_IDLE    = 3'd0,
        POSE_AIR     = 3'd1,
        POSE_PUNCH   = 3'd2,
        POSE_KICK    = 3'd3,
        POSE_RECOVER = 3'd4,
        POSE_STUN    = 3'd5
    } pose_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_JUMP_REQ,
        S_AIR,
        S_PUNCH,
        S_KICK,
        S_RECOVER,
        S_STUN
    } state_t;

    localparam logic [9:0] GROUND_Y = 10'd284;

    localparam int unsigned DEF_PUNCH_FRAMES   = 6;
    localparam int unsigned DEF_KICK_FRAMES    = 10;
    localparam int unsigned DEF_ACTIVE_FIRST   = 2;
    localparam int unsigned DEF_ACTIVE_LAST    = 3;
    localparam int unsigned DEF_RECOVER_FRAMES = 4;
    localparam int unsigned DEF_STUN_FRAMES    = 16;
    localparam int unsigned DEF_JUMP_TIMEOUT   = 2;

    // The jump request still shows the standing sprite until liftoff.
    function automatic pose_t pose_of(state_t s);
        pose_t p;
        p = POSE_IDLE;
        unique case (s)
            S_IDLE:     p = POSE_IDLE;
            S_JUMP_REQ: p = POSE_IDLE;
            S_AIR:      p = POSE_AIR;
            S_PUNCH:    p = POSE_PUNCH;
            S_KICK:     p = POSE_KICK;
            S_RECOVER:  p = POSE_RECOVER;
            S_STUN:     p = POSE_STUN;
            default:    p = POSE_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/fighter_action_ctrl_if.sv
// Signal bundle between the keyboard/collision side and the
// action sequencer.
interface fighter_action_ctrl_if;
    import fighter_pkg::*;

    logic       frame_tick;
    logic [9:0] Ball_Y_Pos;
    logic       jump_key;
    logic       punch_key;
    logic       kick_key;
    logic       hit;

    logic       jump;
    pose_t      pose;
    logic       hitbox_active;
    logic       busy;

    modport master (
        output frame_tick, Ball_Y_Pos,
        output jump_key, punch_key, kick_key, hit,
        input  jump, pose, hitbox_active, busy
    );

    modport slave (
        input  frame_tick, Ball_Y_Pos,
        input  jump_key, punch_key, kick_key, hit,
        output jump, pose, hitbox_active, busy
    );

endinterface

// File: rtl/fighter_action_ctrl_key_edge_latch.sv
// Key sampler with rising-edge detect and a pending bit that lives
// until the next frame tick.
module key_edge_latch (
    input  logic Clk,
    input  logic rst_n,
    input  logic key,
    input  logic clear,
    output logic pending
);

    logic samp;
    logic prev;
    logic rise;

    assign rise = samp & ~prev;

    // A fresh edge wins over the tick so it carries into the next frame.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            samp    <= 1'b0;
            prev    <= 1'b0;
            pending <= 1'b0;
        end else begin
            samp <= key;
            prev <= samp;
            if (rise) begin
                pending <= 1'b1;
            end else if (clear) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fighter_action_ctrl.sv
// Per-fighter action sequencer: arbitrates key requests, holds the
// jump request until liftoff and times attacks, recovery and stun.
module fighter_action_ctrl
    import fighter_pkg::*;
#(
    parameter int unsigned PUNCH_FRAMES   = DEF_PUNCH_FRAMES,
    parameter int unsigned KICK_FRAMES    = DEF_KICK_FRAMES,
    parameter int unsigned ACTIVE_FIRST   = DEF_ACTIVE_FIRST,
    parameter int unsigned ACTIVE_LAST    = DEF_ACTIVE_LAST,
    parameter int unsigned RECOVER_FRAMES = DEF_RECOVER_FRAMES,
    parameter int unsigned STUN_FRAMES    = DEF_STUN_FRAMES,
    parameter int unsigned JUMP_TIMEOUT   = DEF_JUMP_TIMEOUT
) (
    input logic            Clk,
    input logic            Reset_n,
    fighter_action_ctrl_if.slave bus
);

    if (PUNCH_FRAMES   < 1 || PUNCH_FRAMES   > 31 ||
        KICK_FRAMES    < 1 || KICK_FRAMES    > 31 ||
        RECOVER_FRAMES < 1 || RECOVER_FRAMES > 31 ||
        STUN_FRAMES    < 1 || STUN_FRAMES    > 31 ||
        JUMP_TIMEOUT   < 1 || JUMP_TIMEOUT   > 31 ||
        ACTIVE_FIRST   > 31 || ACTIVE_LAST   > 31) begin : g_param_err
        $error("fighter_action_ctrl: frame parameter out of range");
    end

    localparam logic [4:0] P_LAST = 5'(PUNCH_FRAMES - 1);
    localparam logic [4:0] K_LAST = 5'(KICK_FRAMES - 1);
    localparam logic [4:0] R_LAST = 5'(RECOVER_FRAMES - 1);
    localparam logic [4:0] S_LAST = 5'(STUN_FRAMES - 1);
    localparam logic [4:0] J_LAST = 5'(JUMP_TIMEOUT - 1);
    localparam logic [4:0] A_FIRST = 5'(ACTIVE_FIRST);
    localparam logic [4:0] A_LAST  = 5'(ACTIVE_LAST);

    // Assertion is immediate; release is retimed to Clk.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    logic tick;
    logic grounded;
    logic pend_j;
    logic pend_p;
    logic pend_k;

    assign tick     = bus.frame_tick;
    assign grounded = (bus.Ball_Y_Pos >= GROUND_Y);

    key_edge_latch u_jump (
        .Clk     (Clk),
        .rst_n   (rst_n),
        .key     (bus.jump_key),
        .clear   (tick),
        .pending (pend_j)
    );

    key_edge_latch u_punch (
        .Clk     (Clk),
        .rst_n   (rst_n),
        .key     (bus.punch_key),
        .clear   (tick),
        .pending (pend_p)
    );

    key_edge_latch u_kick (
        .Clk     (Clk),
        .rst_n   (rst_n),
        .key     (bus.kick_key),
        .clear   (tick),
        .pending (pend_k)
    );

    state_t     state;
    state_t     nxt;
    logic [4:0] cnt;
    logic [4:0] cnt_nxt;
    logic       atk;
    logic       atk_nxt;
    logic [4:0] atk_last;

    assign atk_last = atk ? K_LAST : P_LAST;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 5'd0;
            atk   <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            atk   <= atk_nxt;
        end
    end

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        atk_nxt = atk;
        if (bus.hit) begin
            nxt     = S_STUN;
            cnt_nxt = 5'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (tick) begin
                        if (pend_j && grounded) begin
                            nxt     = S_JUMP_REQ;
                            cnt_nxt = 5'd0;
                        end else if (pend_k) begin
                            nxt     = S_KICK;
                            cnt_nxt = 5'd0;
                            atk_nxt = 1'b1;
                        end else if (pend_p) begin
                            nxt     = S_PUNCH;
                            cnt_nxt = 5'd0;
                            atk_nxt = 1'b0;
                        end
                    end
                end
                S_JUMP_REQ: begin
                    if (!grounded) begin
                        nxt     = S_AIR;
                        cnt_nxt = 5'd0;
                    end else if (tick) begin
                        if (cnt == J_LAST) begin
                            nxt     = S_IDLE;
                            cnt_nxt = 5'd0;
                        end else begin
                            cnt_nxt = cnt + 5'd1;
                        end
                    end
                end
                S_AIR: begin
                    if (grounded && tick) begin
                        nxt = S_IDLE;
                    end
                end
                S_PUNCH, S_KICK: begin
                    if (tick) begin
                        if (cnt == atk_last) begin
                            nxt     = S_RECOVER;
                            cnt_nxt = 5'd0;
                        end else begin
                            cnt_nxt = cnt + 5'd1;
                        end
                    end
                end
                S_RECOVER: begin
                    if (tick) begin
                        if (cnt == R_LAST) begin
                            nxt     = S_IDLE;
                            cnt_nxt = 5'd0;
                        end else begin
                            cnt_nxt = cnt + 5'd1;
                        end
                    end
                end
                S_STUN: begin
                    if (tick) begin
                        if (cnt == S_LAST) begin
                            nxt     = S_IDLE;
                            cnt_nxt = 5'd0;
                        end else begin
                            cnt_nxt = cnt + 5'd1;
                        end
                    end
                end
                default: begin
                    nxt     = S_IDLE;
                    cnt_nxt = 5'd0;
                end
            endcase
        end
    end

    logic  jump_r;
    pose_t pose_r;
    logic  hb_r;
    logic  busy_r;
    logic  hb_nxt;

    assign hb_nxt = (nxt == S_PUNCH || nxt == S_KICK) &&
                    (cnt_nxt >= A_FIRST) && (cnt_nxt <= A_LAST);

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_r <= 1'b0;
            pose_r <= POSE_IDLE;
            hb_r   <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            jump_r <= (nxt == S_JUMP_REQ);
            pose_r <= pose_of(nxt);
            hb_r   <= hb_nxt;
            busy_r <= (nxt != S_IDLE);
        end
    end

    assign bus.jump          = jump_r;
    assign bus.pose          = pose_r;
    assign bus.hitbox_active = hb_r;
    assign bus.busy          = busy_r;

endmodule

// File: tb/tb_fighter_action_ctrl.sv
// Directed bench for fighter_action_ctrl with hand-computed
// expectations checked by immediate assertions.
module tb_fighter_action_ctrl;
    import fighter_pkg::*;

    logic Clk = 1'b0;
    logic Reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    fighter_action_ctrl_if bus ();

    fighter_action_ctrl dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic j,
                           input logic [2:0] p, input logic h,
                           input logic b);
        chk({tag, ".jump"}, 32'(bus.jump), 32'(j));
        chk({tag, ".pose"}, 32'(bus.pose), 32'(p));
        chk({tag, ".hitbox"}, 32'(bus.hitbox_active), 32'(h));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic frame();
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
        step(3);
    endtask

    initial begin
        Reset_n        = 1'b0;
        bus.frame_tick = 1'b0;
        bus.Ball_Y_Pos = 10'd300;
        bus.jump_key   = 1'b0;
        bus.punch_key  = 1'b0;
        bus.kick_key   = 1'b0;
        bus.hit        = 1'b0;
        step(3);
        chk_all("reset", 0, 0, 0, 0);
        Reset_n = 1'b1;
        step(4);
        frame();
        frame();
        chk_all("idle", 0, 0, 0, 0);

        // jump from the ground, liftoff, landing
        bus.jump_key = 1'b1;
        step(2);
        bus.jump_key = 1'b0;
        frame();
        chk("jreq.jump", 32'(bus.jump), 1);
        chk("jreq.busy", 32'(bus.busy), 1);
        bus.Ball_Y_Pos = 10'd280;
        step(1);
        chk_all("liftoff", 0, 1, 0, 1);
        frame();
        chk_all("airborne", 0, 1, 0, 1);
        bus.Ball_Y_Pos = 10'd300;
        step(1);
        chk_all("land_wait", 0, 1, 0, 1);
        frame();
        chk_all("landed", 0, 0, 0, 0);

        // punch: 6 attack frames, active on 2..3, then 4 recover frames
        bus.punch_key = 1'b1;
        step(2);
        bus.punch_key = 1'b0;
        frame();
        for (int i = 0; i < 6; i++) begin
            chk_all($sformatf("punch%0d", i), 0, 2, (i == 2 || i == 3), 1);
            frame();
        end
        for (int i = 0; i < 4; i++) begin
            chk_all($sformatf("recover%0d", i), 0, 4, 0, 1);
            frame();
        end
        chk_all("punch_done", 0, 0, 0, 0);

        // simultaneous jump/kick/punch: jump wins, others discarded
        bus.jump_key  = 1'b1;
        bus.kick_key  = 1'b1;
        bus.punch_key = 1'b1;
        step(2);
        bus.jump_key  = 1'b0;
        bus.kick_key  = 1'b0;
        bus.punch_key = 1'b0;
        frame();
        chk("multi.jump", 32'(bus.jump), 1);
        chk("multi.pose", 32'(bus.pose), 0);
        bus.Ball_Y_Pos = 10'd280;
        step(1);
        chk_all("multi_air", 0, 1, 0, 1);
        frame();
        bus.Ball_Y_Pos = 10'd300;
        frame();
        chk_all("multi_land", 0, 0, 0, 0);
        frame();
        frame();
        chk_all("multi_after", 0, 0, 0, 0);

        // hit during punch frame 2, re-hit at stun frame 10
        bus.punch_key = 1'b1;
        step(2);
        bus.punch_key = 1'b0;
        frame();
        frame();
        frame();
        chk_all("pre_hit", 0, 2, 1, 1);
        bus.hit = 1'b1;
        step(1);
        bus.hit = 1'b0;
        chk_all("stun_in", 0, 5, 0, 1);
        repeat (10) frame();
        chk_all("stun10", 0, 5, 0, 1);
        bus.hit = 1'b1;
        step(1);
        bus.hit = 1'b0;
        chk_all("rehit", 0, 5, 0, 1);
        for (int i = 1; i <= 16; i++) begin
            frame();
            chk($sformatf("restun%0d.pose", i), 32'(bus.pose),
                (i < 16) ? 32'd5 : 32'd0);
            chk($sformatf("restun%0d.busy", i), 32'(bus.busy),
                (i < 16) ? 32'd1 : 32'd0);
        end

        // hit coinciding with a frame tick
        bus.hit        = 1'b1;
        bus.frame_tick = 1'b1;
        step(1);
        bus.hit        = 1'b0;
        bus.frame_tick = 1'b0;
        chk_all("hit_tick", 0, 5, 0, 1);
        repeat (15) frame();
        chk_all("hit_tick15", 0, 5, 0, 1);
        frame();
        chk_all("hit_tick16", 0, 0, 0, 0);

        // jump timeout at the ground boundary (284 counts as grounded)
        bus.Ball_Y_Pos = 10'd284;
        bus.jump_key   = 1'b1;
        step(2);
        bus.jump_key = 1'b0;
        frame();
        chk("tmo0.jump", 32'(bus.jump), 1);
        chk("tmo0.busy", 32'(bus.busy), 1);
        frame();
        chk("tmo1.jump", 32'(bus.jump), 1);
        frame();
        chk_all("tmo_end", 0, 0, 0, 0);

        // asynchronous reset in the middle of a kick
        bus.Ball_Y_Pos = 10'd300;
        bus.kick_key   = 1'b1;
        step(2);
        bus.kick_key = 1'b0;
        frame();
        chk_all("kick0", 0, 3, 0, 1);
        frame();
        frame();
        chk_all("kick2", 0, 3, 1, 1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        step(2);
        Reset_n = 1'b1;
        step(4);
        frame();
        chk_all("post_rst", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
